// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register indices, exception codes, field positions.
package cp0_pkg;
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int SR_IE       = 0;
  localparam int SR_EXL      = 1;
  localparam int SR_IM_LO    = 10;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO = 10;
  localparam int CAUSE_BD    = 31;

  localparam logic [31:0] DEF_HANDLER = 32'h0000_4180;
endpackage

// File: rtl/cp0_exc_arb.sv
// Interrupt/exception request arbitration; interrupts win over exceptions.
module cp0_exc_arb
  import cp0_pkg::*;
(
  input  logic [5:0] im,
  input  logic       ie,
  input  logic       exl,
  input  logic [5:0] hw_int,
  input  logic [4:0] exc_code_m,
  output logic       int_req,
  output logic       exc_req,
  output logic [4:0] sel_code
);
  assign int_req  = (|(hw_int & im)) & ie & ~exl;
  assign exc_req  = (exc_code_m != 5'd0) & ~exl;
  assign sel_code = int_req ? EXC_INT : exc_code_m;
endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller at the M-stage commit point: SR/Cause/EPC/PrID,
// flush generation and ERET handling.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = DEF_HANDLER,
  parameter logic [31:0] PRID         = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exc_code_m,
  input  logic        eret_m,
  input  logic [5:0]  hw_int,
  input  logic        mtc0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        exc_flush,
  output logic [31:0] handler_pc,
  output logic [31:0] epc_out,
  output logic        exl
);
  logic [5:0]  sr_im;
  logic        sr_exl, sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;
  logic        int_req, exc_req;
  logic [4:0]  sel_code;
  logic [31:0] epc_cap;

  cp0_exc_arb u_arb (
    .im         (sr_im),
    .ie         (sr_ie),
    .exl        (sr_exl),
    .hw_int     (hw_int),
    .exc_code_m (exc_code_m),
    .int_req    (int_req),
    .exc_req    (exc_req),
    .sel_code   (sel_code)
  );

  assign exc_flush  = (int_req | exc_req) & ~reset;
  assign handler_pc = HANDLER_ADDR;
  assign epc_out    = epc;
  assign exl        = sr_exl;
  assign epc_cap    = bd_m ? (pc_m - 32'd4) : pc_m;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= '0;
    end else begin
      cause_ip <= hw_int;
      if (exc_flush) begin
        // MTC0/ERET in the flushed slot are dropped; the instruction replays.
        sr_exl    <= 1'b1;
        cause_bd  <= bd_m;
        cause_exc <= sel_code;
        epc       <= epc_cap & 32'hFFFF_FFFC;
      end else begin
        if (mtc0_we && cp0_addr == CP0_SR) begin
          sr_im  <= wdata[SR_IM_LO +: 6];
          sr_exl <= wdata[SR_EXL];
          sr_ie  <= wdata[SR_IE];
        end
        if (mtc0_we && cp0_addr == CP0_EPC)
          epc <= wdata & 32'hFFFF_FFFC;
        // Later assignment lets ERET override an MTC0 that sets EXL.
        if (eret_m)
          sr_exl <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (cp0_addr)
      CP0_SR: begin
        rdata[SR_IM_LO +: 6] = sr_im;
        rdata[SR_EXL]        = sr_exl;
        rdata[SR_IE]         = sr_ie;
      end
      CP0_CAUSE: begin
        rdata[CAUSE_BD]             = cause_bd;
        rdata[CAUSE_IP_LO +: 6]     = cause_ip;
        rdata[CAUSE_EXC_LO +: 5]    = cause_exc;
      end
      CP0_EPC:  rdata = epc;
      CP0_PRID: rdata = PRID;
      default:  rdata = '0;
    endcase
  end
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed plan plus randomized traffic
// against a word-level register model.
module tb_cp0_exc_ctrl;
  localparam logic [31:0] TB_PRID = 32'hCAFE_0001;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [4:0]  exc_code_m;
  logic        eret_m;
  logic [5:0]  hw_int;
  logic        mtc0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        exc_flush;
  logic [31:0] handler_pc;
  logic [31:0] epc_out;
  logic        exl;

  int nchecks = 0;
  int nerrors = 0;

  cp0_exc_ctrl #(.PRID(TB_PRID)) dut (
    .clk(clk), .reset(reset), .pc_m(pc_m), .bd_m(bd_m),
    .exc_code_m(exc_code_m), .eret_m(eret_m), .hw_int(hw_int),
    .mtc0_we(mtc0_we), .cp0_addr(cp0_addr), .wdata(wdata),
    .rdata(rdata), .exc_flush(exc_flush), .handler_pc(handler_pc),
    .epc_out(epc_out), .exl(exl)
  );

  always #5 clk = ~clk;

  // Model: architectural registers held as whole 32-bit words.
  logic [31:0] m_sr = '0, m_cause = '0, m_epc = '0;

  function automatic logic m_int();
    return ((hw_int & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction
  function automatic logic m_exc();
    return (exc_code_m != 5'd0) && !m_sr[1];
  endfunction
  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return TB_PRID;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_sr = '0; m_cause = '0; m_epc = '0;
    end else if (m_int() || m_exc()) begin
      m_cause = {bd_m, 15'd0, hw_int, 3'd0, (m_int() ? 5'd0 : exc_code_m), 2'd0};
      m_epc   = (bd_m ? pc_m - 32'd4 : pc_m) & ~32'd3;
      m_sr    = m_sr | 32'd2;
    end else begin
      m_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, hw_int} << 10);
      if (mtc0_we && cp0_addr == 5'd12) m_sr = wdata & 32'h0000_FC03;
      if (mtc0_we && cp0_addr == 5'd14) m_epc = wdata & ~32'd3;
      if (eret_m) m_sr = m_sr & ~32'd2;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("flush", {31'd0, exc_flush}, {31'd0, !reset && (m_int() || m_exc())});
    chk("rdata", rdata, m_read(cp0_addr));
    chk("epc_out", epc_out, m_epc);
    chk("exl", {31'd0, exl}, {31'd0, m_sr[1]});
    chk("handler_pc", handler_pc, 32'h0000_4180);
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
    cp0_addr = a; #2;
    chk(name, rdata, exp);
    cyc();
  endtask

  initial begin
    reset = 1'b1; pc_m = '0; bd_m = 0; exc_code_m = '0; eret_m = 0;
    hw_int = '0; mtc0_we = 0; cp0_addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_flush", {31'd0, exc_flush}, 32'd0);
    chk("rst_exl", {31'd0, exl}, 32'd0);
    chk("rst_epc", epc_out, 32'd0);
    rd(12, 32'd0, "rst_sr");
    rd(13, 32'd0, "rst_cause");
    rd(14, 32'd0, "rst_epc_rd");
    rd(15, TB_PRID, "prid");
    rd(3, 32'd0, "unmapped");

    // Enabled interrupt on line 2
    mtc0_we = 1; cp0_addr = 12; wdata = 32'h0000_FC01; cyc(); mtc0_we = 0;
    hw_int = 6'b000100; pc_m = 32'h0000_2000; #2;
    chk("int_flush", {31'd0, exc_flush}, 32'd1);
    cyc();
    #2 chk("int_exl", {31'd0, exl}, 32'd1);
    chk("int_noretrig", {31'd0, exc_flush}, 32'd0);
    rd(13, 32'h0000_1000, "int_cause");
    rd(14, 32'h0000_2000, "int_epc");

    // Overflow in a delay slot
    hw_int = '0; eret_m = 1; cyc(); eret_m = 0;
    chk("eret_clr", {31'd0, exl}, 32'd0);
    exc_code_m = 12; pc_m = 32'h0000_3008; bd_m = 1; #2;
    chk("ov_flush", {31'd0, exc_flush}, 32'd1);
    cyc(); exc_code_m = 0; bd_m = 0;
    rd(13, 32'h8000_0030, "ov_cause");
    rd(14, 32'h0000_3004, "ov_epc");

    // Interrupt beats simultaneous AdEL
    eret_m = 1; cyc(); eret_m = 0;
    hw_int = 6'b000001; exc_code_m = 4; pc_m = 32'h0000_4000; cyc(); exc_code_m = 0;
    rd(13, 32'h0000_0400, "prio_cause");
    rd(14, 32'h0000_4000, "prio_epc");

    // ERET with interrupt still pending: flush in the following cycle
    eret_m = 1; pc_m = 32'h0000_4100; #2;
    chk("eret_noflush", {31'd0, exc_flush}, 32'd0);
    cyc(); eret_m = 0; pc_m = 32'h0000_5000; #2;
    chk("post_eret_exl", {31'd0, exl}, 32'd0);
    chk("post_eret_flush", {31'd0, exc_flush}, 32'd1);
    cyc();
    chk("reint_epc", epc_out, 32'h0000_5000);

    // Flush with coincident MTC0 EPC and ERET
    hw_int = '0; eret_m = 1; cyc();
    exc_code_m = 5; pc_m = 32'h0000_6000; mtc0_we = 1; cp0_addr = 14; wdata = 32'h1234;
    cyc(); exc_code_m = 0; mtc0_we = 0; eret_m = 0;
    chk("coinc_epc", epc_out, 32'h0000_6000);
    chk("coinc_exl", {31'd0, exl}, 32'd1);
    rd(13, 32'h0000_0014, "coinc_cause");

    // Write masking and MTC0 SR with ERET on the same edge
    mtc0_we = 1; cp0_addr = 15; wdata = 32'hFFFF_FFFF; cyc();
    cp0_addr = 12; cyc(); mtc0_we = 0;
    rd(12, 32'h0000_FC03, "sr_mask");
    rd(15, TB_PRID, "prid_ro");
    mtc0_we = 1; cp0_addr = 12; wdata = 32'h0000_FC03; eret_m = 1; cyc();
    mtc0_we = 0; eret_m = 0;
    rd(12, 32'h0000_FC01, "sr_eret_mtc0");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 49) == 0);
      pc_m       = $urandom;
      bd_m       = $urandom_range(0, 1);
      hw_int     = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      exc_code_m = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      eret_m     = ($urandom_range(0, 3) == 0);
      mtc0_we    = ($urandom_range(0, 2) == 0);
      cp0_addr   = $urandom_range(0, 1) ? 5'(12 + $urandom_range(0, 3)) : 5'($urandom);
      wdata      = $urandom;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule

// File: doc/cp0_exc_ctrl.md
# cp0_exc_ctrl

Coprocessor-0 exception/interrupt controller at the M-stage commit point of the pipelined MIPS core. It holds SR, Cause, EPC and PrID, and decides each cycle whether an interrupt or exception is taken. It drives the `exc_flush` that clears every pipeline register, including the W-stage PC/EXLClr register. It consumes the ERET (EXL-clear) event and supplies the EPC return target.

## Interface
- `HANDLER_ADDR`, default 32'h0000_4180: exception entry PC.
- `PRID`, default 32'h0000_0000: read-only processor ID value.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `pc_m`  in  32  PC of the instruction in M.
- `bd_m`  in  1  M instruction is in a branch delay slot.
- `exc_code_m`  in  5  pending exception code for the M instruction; 0 means none.
- `eret_m`  in  1  ERET in M (EXL clear request).
- `hw_int`  in  6  external interrupt lines, level-sensitive.
- `mtc0_we`  in  1  MTC0 write enable from M.
- `cp0_addr`  in  5  CP0 register index for read/write.
- `wdata`  in  32  MTC0 data.
- `rdata`  out  32  MFC0 data.
- `exc_flush`  out  1  take exception/interrupt this cycle; flush all stages.
- `handler_pc`  out  32  constant `HANDLER_ADDR`.
- `epc_out`  out  32  current EPC, used as the ERET target.
- `exl`  out  1  SR.EXL.

## Operation
- **SR (12)**
  - IM = [15:10], EXL = [1], IE = [0].
  - Other bits read 0.
  - MTC0 writes only IM, EXL and IE.
- **Cause (13)**
  - BD = [31], IP = [15:10], ExcCode = [6:2].
  - Other bits read 0.
  - Not MTC0-writable.
  - IP <= `hw_int` every cycle, including during flush.
- **EPC (14)**: fully writable; bits [1:0] are forced to 0 on every update.
- **PrID (15)**: reads `PRID`. Writes to it are ignored.
- **Unmapped reads**: any other index reads 0.
- **Request logic**
  - int_req = |(`hw_int` & IM) & IE & ~EXL.
  - exc_req = (`exc_code_m` != 0) & ~EXL.
  - `exc_flush` = (int_req | exc_req) & ~`reset`.
- **On a clock edge with `exc_flush`**
  - EXL <= 1.
  - BD <= `bd_m`.
  - EPC <= `bd_m` ? `pc_m`-4 : `pc_m`, truncated mod 2^32.
  - ExcCode <= int_req ? 0 : `exc_code_m`. An interrupt wins over a simultaneous exception.
- **On `eret_m` without flush**: EXL <= 0.
- **Priority on one edge**
  - Flush beats ERET, which beats MTC0.
  - An MTC0 or ERET coinciding with a flush is discarded, because the flushed instruction re-executes after return.
- **MTC0 to SR with ERET on the same edge**: EXL <= 0; the IM and IE bits from MTC0 are still written.
- **`rdata`**: combinational from `cp0_addr` and current register values. There is no write-to-read bypass.

## Timing
- **Reset**: SR=0, Cause=0 (IP reloads from `hw_int` on the next edge), EPC=0. Outputs after reset: `exl`=0, `epc_out`=0, `exc_flush`=0.
- **`exc_flush`** is asserted in the same cycle as the request (0-cycle latency). The core redirects fetch to `handler_pc` on that edge.
- **After a flush**: EXL=1 from the next cycle, so `exc_flush` deasserts and cannot retrigger until ERET.
- **ERET**: `epc_out` is stable in the ERET cycle. EXL clears at the edge, and interrupts can be taken from the following cycle.
- **Reset mid-flush**: reset dominates. All registers take their reset values and no EPC capture occurs.

## Structure
- Package `cp0_pkg`:
  - register indices 12/13/14/15;
  - ExcCode constants: Int=0, AdEL=4, AdES=5, RI=10, Ov=12;
  - SR/Cause field bit positions;
  - default handler address.
- One combinational sub-module, `cp0_exc_arb`: inputs IM, IE, EXL, `hw_int`, `exc_code_m`; outputs int_req, exc_req, selected ExcCode.

## Test plan
- Reset, then read 12/13/14/15 -> 0, 0, 0, `PRID`; read index 3 -> 0; `exc_flush`=0.
- MTC0 SR=32'h0000_FC01, set `hw_int`=6'b000100 -> `exc_flush`=1 that cycle. Next cycle: ExcCode=0, Cause IP=6'b000100, EXL=1, `exc_flush`=0.
- `exc_code_m`=12, `pc_m`=32'h0000_3008, `bd_m`=1 -> EPC=32'h0000_3004, BD=1, ExcCode=12.
- Interrupt and `exc_code_m`=4 in the same cycle -> ExcCode=0, EPC=`pc_m`.
- With EXL=1, assert `eret_m` -> EXL=0 next cycle. A pending enabled interrupt then flushes in the following cycle.
- Flush coinciding with MTC0 EPC=32'h1234 and with `eret_m` -> EPC=`pc_m` (MTC0 discarded), EXL=1.
